// File: rtl/cl_frame_gen.sv
// Camera Link video source: FVAL/LVAL/DVAL framing plus N_TAPS-wide test pattern on cl_pclk.
// Latency: enable seen in IDLE at edge k -> cl_fval high after edge k; first LVAL FV_SETUP cycles later.
// Backpressure: none (free-running source); enable is honoured only at IDLE or at the VBLANK exit.
module cl_frame_gen #(
    parameter int N_TAPS   = 10,
    parameter int PIX_W    = 8,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 16,
    parameter int FV_SETUP = 4,
    parameter int V_BLANK  = 64
) (
    input  logic                      cl_pclk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [1:0]                mode,
    output logic                      cl_fval,
    output logic                      cl_lval,
    output logic                      cl_dval,
    output logic [N_TAPS*PIX_W-1:0]   cl_data,
    output logic [15:0]               frame_cnt,
    output logic                      busy
);

    localparam int BEATS = H_ACTIVE / N_TAPS;
    localparam int SU_W  = $clog2(FV_SETUP + 1);
    localparam int BT_W  = $clog2(BEATS + 1);
    localparam int HB_W  = $clog2(H_BLANK + 1);
    localparam int VB_W  = $clog2(V_BLANK + 1);
    localparam int LN_W  = $clog2(V_ACTIVE + 1);

    localparam logic [SU_W-1:0] SU_LAST = SU_W'(FV_SETUP - 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BEATS - 1);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(H_BLANK - 1);
    localparam logic [VB_W-1:0] VB_LAST = VB_W'(V_BLANK - 1);
    localparam logic [LN_W-1:0] LN_LAST = LN_W'(V_ACTIVE - 1);
    localparam logic [15:0]     LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {IDLE, SETUP, LINE, HBLANK, TAIL, VBLANK} state_t;

    state_t                  state, next_state;
    logic [SU_W-1:0]         su_cnt;
    logic [BT_W-1:0]         beat_cnt;
    logic [HB_W-1:0]         hb_cnt;
    logic [VB_W-1:0]         vb_cnt;
    logic [LN_W-1:0]         line_cnt;
    logic [1:0]              mode_q;
    logic [15:0]             lfsr;
    logic [15:0]             lfsr_adv;
    logic [15:0]             lfsr_use;
    logic [BT_W-1:0]         nxt_beat;
    logic [LN_W-1:0]         nxt_line;
    logic [31:0]             pix32;
    logic [N_TAPS*PIX_W-1:0] nxt_data;
    logic                    frame_start;

    // Next-state decode; each timed state leaves when its own counter reaches its last cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = SETUP;
            SETUP:   if (su_cnt == SU_LAST) next_state = LINE;
            LINE:    if (beat_cnt == BT_LAST) next_state = (line_cnt == LN_LAST) ? TAIL : HBLANK;
            HBLANK:  if (hb_cnt == HB_LAST) next_state = LINE;
            TAIL:    if (su_cnt == SU_LAST) next_state = VBLANK;
            VBLANK:  if (vb_cnt == VB_LAST) next_state = enable ? SETUP : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pattern for the beat that will be on the bus after this edge (outputs are registered)
    always_comb begin
        frame_start = (next_state == SETUP) && (state != SETUP);
        lfsr_adv    = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        lfsr_use    = (state == LINE) ? lfsr_adv : lfsr;
        nxt_beat    = (state == LINE) ? beat_cnt + 1'b1 : '0;
        nxt_line    = (state == HBLANK) ? line_cnt + 1'b1 : line_cnt;
        nxt_data    = '0;
        pix32       = '0;
        for (int t = 0; t < N_TAPS; t++) begin
            case (mode_q)
                2'd1:    pix32 = 32'(nxt_beat) * 32'(N_TAPS) + 32'(t) + 32'(nxt_line);
                2'd2:    pix32 = 32'(frame_cnt);
                2'd3:    pix32 = 32'(lfsr_use) ^ 32'(t);
                default: pix32 = '0;
            endcase
            nxt_data[t*PIX_W +: PIX_W] = pix32[PIX_W-1:0];
        end
    end

    // State, per-state counters, latched mode, LFSR and registered outputs
    always_ff @(posedge cl_pclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            su_cnt    <= '0;
            beat_cnt  <= '0;
            hb_cnt    <= '0;
            vb_cnt    <= '0;
            line_cnt  <= '0;
            mode_q    <= '0;
            lfsr      <= LFSR_SEED;
            frame_cnt <= '0;
            cl_fval   <= 1'b0;
            cl_lval   <= 1'b0;
            cl_data   <= '0;
            busy      <= 1'b0;
        end else begin
            state    <= next_state;
            su_cnt   <= ((state == SETUP || state == TAIL) && next_state == state) ? su_cnt + 1'b1 : '0;
            beat_cnt <= (state == LINE   && next_state == LINE)   ? beat_cnt + 1'b1 : '0;
            hb_cnt   <= (state == HBLANK && next_state == HBLANK) ? hb_cnt + 1'b1   : '0;
            vb_cnt   <= (state == VBLANK && next_state == VBLANK) ? vb_cnt + 1'b1   : '0;
            if (frame_start)
                line_cnt <= '0;
            else if (state == HBLANK && next_state == LINE)
                line_cnt <= line_cnt + 1'b1;
            if (frame_start)
                mode_q <= mode;
            if (frame_start)
                lfsr <= LFSR_SEED;
            else if (state == LINE)
                lfsr <= lfsr_adv;
            if (state == TAIL && next_state == VBLANK)
                frame_cnt <= frame_cnt + 16'd1;
            cl_fval <= (next_state == SETUP) || (next_state == LINE) ||
                       (next_state == HBLANK) || (next_state == TAIL);
            cl_lval <= (next_state == LINE);
            cl_data <= (next_state == LINE) ? nxt_data : '0;
            busy    <= (next_state != IDLE);
        end
    end

    assign cl_dval = cl_lval;

endmodule

// File: tb/tb_cl_frame_gen.sv
// Randomised bench for cl_frame_gen with a position-based frame model and a data scoreboard.
// Latency: model advances on each rising edge; monitor compares on the falling edge.
// Backpressure: none; the scoreboard pops one expected beat per DUT data-valid cycle.
module tb_cl_frame_gen;

    localparam int N_TAPS   = 2;
    localparam int PIX_W    = 8;
    localparam int H_ACTIVE = 8;
    localparam int V_ACTIVE = 3;
    localparam int H_BLANK  = 2;
    localparam int FV_SETUP = 1;
    localparam int V_BLANK  = 4;
    localparam int DW       = N_TAPS * PIX_W;
    localparam int BEATS    = H_ACTIVE / N_TAPS;
    localparam int LINE_PER = BEATS + H_BLANK;
    localparam int FVAL_LEN = 2 * FV_SETUP + V_ACTIVE * BEATS + (V_ACTIVE - 1) * H_BLANK;
    localparam int PERIOD   = FVAL_LEN + V_BLANK;
    localparam int F_BEATS  = V_ACTIVE * BEATS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          cl_fval, cl_lval, cl_dval, busy;
    logic [DW-1:0] cl_data;
    logic [15:0]   frame_cnt;

    cl_frame_gen #(
        .N_TAPS(N_TAPS), .PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
        .H_BLANK(H_BLANK), .FV_SETUP(FV_SETUP), .V_BLANK(V_BLANK)
    ) dut (
        .cl_pclk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .cl_fval(cl_fval), .cl_lval(cl_lval), .cl_dval(cl_dval), .cl_data(cl_data),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // LFSR sequence for one frame, indexed by beat number within the frame
    int lfsr_tab [0:F_BEATS-1];

    function automatic int lfsr_step(input int x);
        int fb;
        fb = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
        return ((x >> 1) | (fb << 15)) & 16'hFFFF;
    endfunction

    function automatic logic [DW-1:0] exp_pix(input int md, input int l, input int b, input int fr);
        logic [DW-1:0] r;
        int v;
        r = '0;
        for (int t = 0; t < N_TAPS; t++) begin
            case (md)
                0:       v = 0;
                1:       v = b * N_TAPS + t + l;
                2:       v = fr;
                default: v = lfsr_tab[l * BEATS + b] ^ t;
            endcase
            r[t*PIX_W +: PIX_W] = PIX_W'(v % (1 << PIX_W));
        end
        return r;
    endfunction

    // Reference model: position p within the frame period decides everything
    bit            running = 0;
    int            p = 0;
    int            m_mode = 0;
    int            m_frame = 0;
    int            m_line = 0;
    int            m_beat = 0;
    bit            e_fval = 0, e_lval = 0, e_busy = 0;
    logic [DW-1:0] sb_q [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running = 0; p = 0; m_mode = 0; m_frame = 0;
            e_fval = 0; e_lval = 0; e_busy = 0;
            sb_q.delete();
        end else begin
            if (!running) begin
                if (enable) begin
                    running = 1; p = 0; m_mode = int'(mode);
                end
            end else if (p == PERIOD - 1) begin
                if (enable) begin
                    p = 0; m_mode = int'(mode);
                end else begin
                    running = 0;
                end
            end else begin
                p = p + 1;
                if (p == FVAL_LEN) m_frame = m_frame + 1;
            end
            e_busy = running;
            e_fval = running && (p < FVAL_LEN);
            e_lval = 0;
            if (running && p >= FV_SETUP && (p - FV_SETUP) < V_ACTIVE * LINE_PER - H_BLANK) begin
                m_line = (p - FV_SETUP) / LINE_PER;
                m_beat = (p - FV_SETUP) % LINE_PER;
                e_lval = (m_beat < BEATS);
            end
            if (e_lval) sb_q.push_back(exp_pix(m_mode, m_line, m_beat, m_frame));
        end
    end

    // Monitor: per-cycle framing check, scoreboard pop on data valid, pulse-length checks
    int fv_run = 0;
    int lv_run = 0;
    logic [DW-1:0] exp_d;

    always @(negedge clk) begin
        if (!reset_n) begin
            fv_run = 0;
            lv_run = 0;
        end else begin
            check("framing{fval,lval,dval,busy,frame_cnt}",
                  {44'd0, cl_fval, cl_lval, cl_dval, busy, frame_cnt},
                  {44'd0, e_fval, e_lval, e_lval, e_busy, 16'(m_frame)});
            if (cl_dval) begin
                if (sb_q.size() == 0) begin
                    check("scoreboard_underflow", 64'(cl_data), 64'hDEAD_0000);
                end else begin
                    exp_d = sb_q.pop_front();
                    check("pixel_data", 64'(cl_data), 64'(exp_d));
                end
            end else begin
                check("data_zero_outside_lval", 64'(cl_data), 64'd0);
            end
            if (cl_fval) fv_run++;
            else if (fv_run > 0) begin
                check("fval_high_length", 64'(fv_run), 64'(FVAL_LEN));
                fv_run = 0;
            end
            if (cl_lval) lv_run++;
            else if (lv_run > 0) begin
                check("lval_high_length", 64'(lv_run), 64'(BEATS));
                lv_run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_frames(input int target, input string name);
        int i;
        for (i = 0; i < 2000 && m_frame < target; i++) @(negedge clk);
        check(name, 64'(m_frame >= target), 64'd1);
    endtask

    task automatic wait_pos(input int pos, input string name);
        int i;
        for (i = 0; i < 500 && !(running && p == pos); i++) @(negedge clk);
        check(name, 64'(running && p == pos), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 500 && running; i++) @(negedge clk);
        check(name, 64'(running), 64'd0);
    endtask

    initial begin
        lfsr_tab[0] = 16'hACE1;
        for (int k = 1; k < F_BEATS; k++) lfsr_tab[k] = lfsr_step(lfsr_tab[k-1]);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {39'd0, cl_fval, cl_lval, cl_dval, busy, cl_data, frame_cnt}, 64'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Ramp frame; switch mode to zero mid-frame, next frame must be all-zero
        mode = 2'd1;
        enable = 1'b1;
        @(negedge clk);
        check("fval_after_enable", 64'(cl_fval), 64'd1);
        wait_pos(FVAL_LEN / 2, "wait_mid_frame0");
        mode = 2'd0;
        wait_frames(2, "wait_frame2");

        // Frame-number pattern over three frames
        mode = 2'd2;
        wait_frames(5, "wait_frame5");

        // LFSR pattern over two frames
        mode = 2'd3;
        wait_frames(7, "wait_frame7");

        // Random mode changes and enable toggles
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) enable = ~enable;
        end
        enable = 1'b1;

        // Drop enable during line 1: frame completes, then block goes idle
        wait_pos(FV_SETUP + LINE_PER, "wait_line1");
        enable = 1'b0;
        wait_idle("wait_idle_after_drop");
        repeat (10) @(negedge clk);
        check("idle_after_drop{fval,busy}", {62'd0, cl_fval, busy}, 64'd0);

        // Reset pulse during a line
        mode = 2'd1;
        enable = 1'b1;
        wait_pos(FV_SETUP + LINE_PER + 1, "wait_line1_reset");
        #3 reset_n = 1'b0;
        #1 check("async_reset_outputs", {39'd0, cl_fval, cl_lval, cl_dval, busy, cl_data, frame_cnt}, 64'd0);
        @(negedge clk);
        #3 reset_n = 1'b1;
        wait_frames(1, "wait_frame_after_reset");
        enable = 1'b0;
        wait_idle("wait_final_idle");
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
